// File: rtl/if_id_stage_if.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | Module   : if_id_stage_if                                               |
// | Brief    : Hazard/branch/imem inputs and IF/ID outputs of if_id_stage.  |
// |            Perf counter signals present when IF_ID_PERF_COUNT_EN is set.|
// | Revision : 1.0                                                          |
// +-------------------------------------------------------------------------+
interface if_id_stage_if;
  logic        StallIn;
  logic        FlushIn;
  logic [31:0] BranchTargetIn;
  logic [31:0] InstrIn;
  logic [31:0] PCOut;
  logic [31:0] PCAddOut;
  logic [31:0] InstrOut;
  logic [4:0]  Instr2521Out;
  logic [4:0]  Instr2016Out;
  logic [4:0]  Instr1511Out;
  logic [4:0]  Instr106Out;
  logic [15:0] Imm150Out;
  logic        ValidOut;
  logic        StallErrOut;
`ifdef IF_ID_PERF_COUNT_EN
  logic [31:0] StallCountOut;
  logic [31:0] FlushCountOut;
`endif

  // The fetch stage itself
  modport slave (
    input  StallIn, FlushIn, BranchTargetIn, InstrIn,
    output PCOut, PCAddOut, InstrOut, Instr2521Out, Instr2016Out,
           Instr1511Out, Instr106Out, Imm150Out, ValidOut, StallErrOut
`ifdef IF_ID_PERF_COUNT_EN
    , output StallCountOut, FlushCountOut
`endif
  );

  // Hazard unit / branch logic / instruction memory side
  modport master (
    output StallIn, FlushIn, BranchTargetIn, InstrIn,
    input  PCOut, PCAddOut, InstrOut, Instr2521Out, Instr2016Out,
           Instr1511Out, Instr106Out, Imm150Out, ValidOut, StallErrOut
`ifdef IF_ID_PERF_COUNT_EN
    , input StallCountOut, FlushCountOut
`endif
  );
endinterface
`default_nettype wire

// File: rtl/if_id_stage.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | Module   : if_id_stage                                                  |
// | Brief    : MIPS fetch front end: PC, PC+4, IF/ID register, stall/flush, |
// |            stall watchdog. Optional IF_ID_PERF_COUNT_EN perf counters.  |
// | Revision : 1.0                                                          |
// +-------------------------------------------------------------------------+
module if_id_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MAX_STALL = 15
) (
  input  wire logic     Clk,
  input  wire logic     Rst_n,
  if_id_stage_if.slave  bus
);

  localparam logic [8:0] c_ERR_LEN = 9'(MAX_STALL + 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    HOLD     = 2'd1,
    REDIRECT = 2'd2
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc, r_pcadd, r_instr;
  logic        r_valid, r_err;
  logic [7:0]  r_stall_cnt;

  logic [31:0] w_pc_plus4;
  logic [31:0] w_pc_nxt, w_pcadd_nxt, w_instr_nxt;
  logic        w_valid_nxt, w_err_nxt;
  logic [7:0]  w_cnt_nxt;
  logic [8:0]  w_run_len;

  assign w_pc_plus4 = r_pc + 32'd4;

  always_ff @(negedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state     <= RUN;
      r_pc        <= RESET_PC;
      r_pcadd     <= 32'd0;
      r_instr     <= 32'd0;
      r_valid     <= 1'b0;
      r_err       <= 1'b0;
      r_stall_cnt <= 8'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_pcadd     <= w_pcadd_nxt;
      r_instr     <= w_instr_nxt;
      r_valid     <= w_valid_nxt;
      r_err       <= w_err_nxt;
      r_stall_cnt <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = RUN;
    w_pc_nxt    = r_pc;
    w_pcadd_nxt = r_pcadd;
    w_instr_nxt = r_instr;
    w_valid_nxt = r_valid;
    w_err_nxt   = r_err;
    w_cnt_nxt   = 8'd0;
    // A stall run only continues if the previous edge also stalled; the
    // 9-bit sum lets MAX_STALL=255 still reach its 256-edge threshold.
    w_run_len   = {1'b0, (r_state == HOLD) ? r_stall_cnt : 8'd0} + 9'd1;

    if (bus.FlushIn) begin
      w_state_nxt = REDIRECT;
      w_pc_nxt    = bus.BranchTargetIn;
      w_pcadd_nxt = 32'd0;
      w_instr_nxt = 32'd0;
      w_valid_nxt = 1'b0;
    end else if (bus.StallIn) begin
      w_state_nxt = HOLD;
      w_cnt_nxt   = w_run_len[8] ? 8'hFF : w_run_len[7:0];
      if (w_run_len >= c_ERR_LEN) begin
        w_err_nxt = 1'b1;
      end
    end else begin
      w_state_nxt = RUN;
      w_pc_nxt    = w_pc_plus4;
      w_pcadd_nxt = w_pc_plus4;
      w_instr_nxt = bus.InstrIn;
      w_valid_nxt = 1'b1;
    end
  end

  assign bus.PCOut        = r_pc;
  assign bus.PCAddOut     = r_pcadd;
  assign bus.InstrOut     = r_instr;
  assign bus.Instr2521Out = r_instr[25:21];
  assign bus.Instr2016Out = r_instr[20:16];
  assign bus.Instr1511Out = r_instr[15:11];
  assign bus.Instr106Out  = r_instr[10:6];
  assign bus.Imm150Out    = r_instr[15:0];
  assign bus.ValidOut     = r_valid;
  assign bus.StallErrOut  = r_err;

`ifdef IF_ID_PERF_COUNT_EN
  logic [31:0] r_stall_total, r_flush_total;

  always_ff @(negedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_stall_total <= 32'd0;
      r_flush_total <= 32'd0;
    end else if (bus.FlushIn) begin
      if (r_flush_total != 32'hFFFF_FFFF) begin
        r_flush_total <= r_flush_total + 32'd1;
      end
    end else if (bus.StallIn) begin
      if (r_stall_total != 32'hFFFF_FFFF) begin
        r_stall_total <= r_stall_total + 32'd1;
      end
    end
  end

  assign bus.StallCountOut = r_stall_total;
  assign bus.FlushCountOut = r_flush_total;
`endif

endmodule
`default_nettype wire

// File: tb/tb_if_id_stage.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | Module   : tb_if_id_stage                                               |
// | Brief    : Directed + random bench for if_id_stage against a reference  |
// |            model. Honours IF_ID_PERF_COUNT_EN. Revision : 1.0           |
// +-------------------------------------------------------------------------+
module tb_if_id_stage;

  localparam logic [31:0] c_RESET_PC  = 32'h0000_0040;
  localparam int          c_MAX_STALL = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, flush;
  logic [31:0] target;
  logic        chk_en = 1'b0;
  int          nchecks = 0;
  int          nerrs = 0;

  if_id_stage_if bus();

  if_id_stage #(.RESET_PC(c_RESET_PC), .MAX_STALL(c_MAX_STALL)) dut (
    .Clk   (clk),
    .Rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Instruction memory: a fixed scramble of the address
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1111_1111;
  endfunction

  assign bus.StallIn        = stall;
  assign bus.FlushIn        = flush;
  assign bus.BranchTargetIn = target;
  assign bus.InstrIn        = mem_word(bus.PCOut);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: what the IF/ID outputs must be after each falling edge
  logic [31:0] m_pc = c_RESET_PC, m_pcadd = 0, m_instr = 0;
  logic        m_valid = 0, m_err = 0;
  int          m_run = 0;
  longint      m_sc = 0, m_fc = 0;

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc = c_RESET_PC; m_pcadd = 0; m_instr = 0;
      m_valid = 0; m_err = 0; m_run = 0; m_sc = 0; m_fc = 0;
    end else if (flush) begin
      m_pc = target; m_pcadd = 0; m_instr = 0; m_valid = 0; m_run = 0;
      if (m_fc < 64'hFFFF_FFFF) m_fc++;
    end else if (stall) begin
      m_run++;
      if (m_run > c_MAX_STALL) m_err = 1;
      if (m_sc < 64'hFFFF_FFFF) m_sc++;
    end else begin
      m_instr = mem_word(m_pc);
      m_pc    = m_pc + 32'd4;
      m_pcadd = m_pc;
      m_valid = 1;
      m_run   = 0;
    end
  end

  // Compare process: outputs only move on falling edges, so sample on rising
  always @(posedge clk) begin
    if (chk_en) begin
      check("pc", bus.PCOut, m_pc);
      check("pcadd", bus.PCAddOut, m_pcadd);
      check("instr", bus.InstrOut, m_instr);
      check("rs", 32'(bus.Instr2521Out), 32'(m_instr >> 21) & 32'h1F);
      check("rt", 32'(bus.Instr2016Out), 32'(m_instr >> 16) & 32'h1F);
      check("rd", 32'(bus.Instr1511Out), 32'(m_instr >> 11) & 32'h1F);
      check("shamt", 32'(bus.Instr106Out), 32'(m_instr >> 6) & 32'h1F);
      check("imm", 32'(bus.Imm150Out), m_instr & 32'hFFFF);
      check("valid", 32'(bus.ValidOut), 32'(m_valid));
      check("stallerr", 32'(bus.StallErrOut), 32'(m_err));
`ifdef IF_ID_PERF_COUNT_EN
      check("stallcnt", bus.StallCountOut, m_sc[31:0]);
      check("flushcnt", bus.FlushCountOut, m_fc[31:0]);
`endif
    end
  end

  // Apply inputs for one falling edge, then land just after it
  task automatic edge_(input logic s, input logic f, input logic [31:0] t);
    stall = s; flush = f; target = t;
    @(negedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pc"}, bus.PCOut, c_RESET_PC);
    check({tag, "_pcadd"}, bus.PCAddOut, 32'd0);
    check({tag, "_instr"}, bus.InstrOut, 32'd0);
    check({tag, "_imm"}, 32'(bus.Imm150Out), 32'd0);
    check({tag, "_valid"}, 32'(bus.ValidOut), 32'd0);
    check({tag, "_err"}, 32'(bus.StallErrOut), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    stall = 0; flush = 0; target = 0;
    rst_n = 1'b1;
    #3 rst_n = 1'b0;
    chk_en = 1'b1;
    #1 check_reset_outputs("reset");
    @(posedge clk); #2 rst_n = 1'b1;

    // Sequential fetch from RESET_PC
    edge_(0, 0, 0);
    check("adv1_pc", bus.PCOut, 32'h44);
    check("adv1_pcadd", bus.PCAddOut, 32'h44);
    check("adv1_instr", bus.InstrOut, 32'h1111_1111 ^ (32'h40 * 32'h9E37_79B1));
    check("adv1_valid", 32'(bus.ValidOut), 32'd1);
    edge_(0, 0, 0);
    check("adv2_pc", bus.PCOut, 32'h48);
    check("adv2_pcadd", bus.PCAddOut, 32'h48);
    edge_(0, 0, 0);
    check("adv3_pc", bus.PCOut, 32'h4C);
    check("adv3_pcadd", bus.PCAddOut, 32'h4C);

    // Load-use stall at PC=0x10, three edges: below watchdog threshold
    edge_(0, 1, 32'h0C);
    check("fl_c_pc", bus.PCOut, 32'h0C);
    check("fl_c_valid", 32'(bus.ValidOut), 32'd0);
    edge_(0, 0, 0);
    check("pre_stall_pc", bus.PCOut, 32'h10);
    for (int i = 0; i < 3; i++) begin
      edge_(1, 0, 0);
      check("stall_pc", bus.PCOut, 32'h10);
      check("stall_pcadd", bus.PCAddOut, 32'h10);
      check("stall_instr", bus.InstrOut, mem_word(32'h0C));
    end
    check("wd3_err", 32'(bus.StallErrOut), 32'd0);
    edge_(0, 0, 0);
    check("rel_instr", bus.InstrOut, mem_word(32'h10));
    check("rel_pc", bus.PCOut, 32'h14);
    edge_(0, 0, 0);
    check("rel2_instr", bus.InstrOut, mem_word(32'h14));
    check("wd3_err_after", 32'(bus.StallErrOut), 32'd0);

    // Four-edge stall trips the watchdog, which stays sticky
    for (int i = 0; i < 3; i++) edge_(1, 0, 0);
    check("wd_before_4th", 32'(bus.StallErrOut), 32'd0);
    edge_(1, 0, 0);
    check("wd_4th", 32'(bus.StallErrOut), 32'd1);
    edge_(0, 0, 0);
    check("wd_sticky", 32'(bus.StallErrOut), 32'd1);

    // Flush wins over stall
    edge_(1, 1, 32'h200);
    check("fl_pc", bus.PCOut, 32'h200);
    check("fl_instr", bus.InstrOut, 32'd0);
    check("fl_valid", 32'(bus.ValidOut), 32'd0);
    check("fl_pcadd", bus.PCAddOut, 32'd0);
    edge_(0, 0, 0);
    check("fl_next_instr", bus.InstrOut, mem_word(32'h200));
    check("fl_next_valid", 32'(bus.ValidOut), 32'd1);
    check("fl_next_pcadd", bus.PCAddOut, 32'h204);

    // PC wrap
    edge_(0, 1, 32'hFFFF_FFFC);
    edge_(0, 0, 0);
    check("wrap_pc", bus.PCOut, 32'd0);
    check("wrap_pcadd", bus.PCAddOut, 32'd0);
    check("wrap_instr", bus.InstrOut, mem_word(32'hFFFF_FFFC));

    // Asynchronous reset in the middle of a stall
    edge_(1, 0, 0);
    edge_(1, 0, 0);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async");
    stall = 0;
    #2 rst_n = 1'b1;

`ifdef IF_ID_PERF_COUNT_EN
    for (int i = 0; i < 5; i++) edge_(1, 0, 0);
    for (int i = 0; i < 2; i++) edge_(0, 1, 32'h100);
    check("perf_stall", bus.StallCountOut, 32'd5);
    check("perf_flush", bus.FlushCountOut, 32'd2);
    #2 rst_n = 1'b0;
    #1 rst_n = 1'b1;
`endif

    // Randomized traffic, including occasional mid-cycle resets
    for (int n = 0; n < 500; n++) begin
      int r;
      logic [31:0] t;
      r = int'($urandom_range(0, 99));
      t = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : $urandom;
      edge_(r >= 8 && r < 50, r < 8, t);
      if ($urandom_range(0, 99) == 0) begin
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
    end

    stall = 0; flush = 0;
    @(posedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
    $finish;
  end

endmodule
`default_nettype wire
